pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: duty-cycle width, matching the driven pwm instance.
REQ-002 SHALL have parameter PERIOD_CLK_COUNT, default 2000000: clocks per PWM period, matching the pwm instance.
REQ-003 SHALL have parameter STEP_PERIODS, default 1: PWM periods between duty steps; legal values are 1 or greater.
REQ-004 SHALL have port clkIn, input, width 1: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rstnIn, input, width 1: reset, asynchronous and active-low.
REQ-006 SHALL have port cmdValidIn, input, width 1: a ramp command is offered.
REQ-007 SHALL have port cmdReadyOut, output, width 1: a command is accepted on any cycle where cmdValidIn and cmdReadyOut are both 1.
REQ-008 SHALL have port cmdTargetIn, input, width N: target duty cycle.
REQ-009 SHALL have port cmdStepIn, input, width N: duty increment per step; a value of 0 is treated as 1.
REQ-010 SHALL have port stopIn, input, width 1: level request to ramp down to 0 and disable.
REQ-011 SHALL have port pwmEnOut, output, width 1: drives the pwm enIn.
REQ-012 SHALL have port dutyCycleOut, output, width N: drives the pwm dutyCycleIn.
REQ-013 SHALL have port busyOut, output, width 1: high in states RAMP or STOP.
REQ-014 SHALL have port doneOut, output, width 1: a one-cycle pulse when a ramp completes.
REQ-015 SHALL have port periodTickOut, output, width 1: a one-cycle pulse on the last clock of each PWM period.

Function
REQ-016 SHALL implement the states IDLE, RAMP, HOLD and STOP.
REQ-017 SHALL keep a period counter that runs 0..PERIOD_CLK_COUNT-1 and advances only while pwmEnOut=1; it holds otherwise, so it stays in lockstep with the pwm counter.
REQ-018 SHALL assert periodTickOut when the period counter equals PERIOD_CLK_COUNT-1 and pwmEnOut=1.
REQ-019 SHALL keep a step counter that counts ticks modulo STEP_PERIODS; a step occurs on every STEP_PERIODS-th tick.
REQ-020 SHALL update dutyCycleOut only on a step, so duty changes fall on PWM period boundaries.
REQ-021 SHALL set cmdReadyOut=1 in IDLE and HOLD, and 0 in RAMP and STOP.
REQ-022 SHALL, on command accept in IDLE: latch the target and step, clear the period and step counters, set pwmEnOut=1 on the next cycle with dutyCycleOut=0, and go to RAMP.
REQ-023 SHALL, on command accept in HOLD: latch the target and step, clear the step counter only, and go to RAMP starting from the current duty.
REQ-024 SHALL, on each RAMP step going up: set duty = target if (target-duty) <= step, else duty+step; the arithmetic is N+1 bits wide, with no overflow or wrap.
REQ-025 SHALL, on each RAMP step going down: set duty = target if (duty-target) <= step, else duty-step; there is no underflow.
REQ-026 SHALL, when duty equals target after a step, or on accept when target equals current duty, go to HOLD and pulse doneOut for one cycle; in the accept case doneOut is on the cycle after accept.
REQ-027 SHALL, in HOLD, keep the duty and pwmEnOut constant.
REQ-028 SHALL, when stopIn=1 in RAMP or HOLD, go to STOP on the next cycle without clearing the counters.
REQ-029 SHALL give stopIn priority over a simultaneous cmdValidIn, which is then not accepted.
REQ-030 SHALL, in STOP, step the duty toward 0 using the latched step.
REQ-031 SHALL, when duty reaches 0 in STOP, pulse doneOut and go to IDLE with pwmEnOut=0 on the same edge.
REQ-032 SHALL ignore stopIn in IDLE and STOP.
REQ-033 SHALL ignore the command inputs when cmdReadyOut=0.

Reset
REQ-034 SHALL, while rstnIn=0, force state IDLE, pwmEnOut=0, dutyCycleOut=0, busyOut=0, doneOut=0, periodTickOut=0, cmdReadyOut=0, and clear all counters and latched fields.
REQ-035 SHALL set cmdReadyOut=1 on the first clock edge after rstnIn deasserts.
REQ-036 SHALL, on reset asserted mid-ramp, immediately drive pwmEnOut=0 and dutyCycleOut=0 without waiting for a clock.

Verification (N=4, PERIOD_CLK_COUNT=32, STEP_PERIODS=2)
REQ-037 SHALL cover ramp up: in IDLE, command target=10, step=4 -> dutyCycleOut=4 at tick 2, 8 at tick 4, 10 at tick 6, doneOut pulses once, state HOLD, cmdReadyOut=1.
REQ-038 SHALL cover ramp down from HOLD: at duty 10, command target=3, step=5 -> duty 5 at tick 2, 3 at tick 4, then done; every duty change coincides with a periodTickOut.
REQ-039 SHALL cover stop: stopIn=1 during a ramp at duty 8 with step 4 -> STOP, duty 4 then 0, doneOut pulses, pwmEnOut=0 and busyOut=0 in the same cycle.
REQ-040 SHALL cover edge cases: step=0 gives 1-per-step increments; target=15, step=15 from 0 gives 15 in one step; command target equal to current duty in HOLD gives doneOut on the next cycle with no duty change.
REQ-041 SHALL cover simultaneous inputs: stopIn=1 with cmdValidIn=1 in HOLD -> no command accepted, STOP is entered.
REQ-042 SHALL cover reset mid-operation: rstnIn pulsed low between clock edges during RAMP -> outputs are 0 immediately, IDLE after release, and a new command ramps normally.

Source files
------------

// File: rtl/pwm_ramp_ctrl_if.sv
// rtl/pwm_ramp_ctrl_if.sv - ramp command handshake bundle
// Carries one ramp command (target duty and step size) from a host to the ramp controller.
interface pwm_ramp_ctrl_if #(
  parameter int N = 8
);
  logic         tvalid;
  logic         tready;
  logic [N-1:0] target;
  logic [N-1:0] step;

  modport master (
    output tvalid,
    output target,
    output step,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  target,
    input  step,
    output tready
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - duty-cycle ramp sequencer for a pwm instance
// Steps the duty toward a commanded target on PWM period boundaries; stop ramps down to 0 and disables.
module pwm_ramp_ctrl #(
  parameter int N                = 8,
  parameter int PERIOD_CLK_COUNT = 2000000,
  parameter int STEP_PERIODS     = 1
) (
  input  logic         clkIn,
  input  logic         rstnIn,
  input  logic         cmdValidIn,
  output logic         cmdReadyOut,
  input  logic [N-1:0] cmdTargetIn,
  input  logic [N-1:0] cmdStepIn,
  input  logic         stopIn,
  output logic         pwmEnOut,
  output logic [N-1:0] dutyCycleOut,
  output logic         busyOut,
  output logic         doneOut,
  output logic         periodTickOut
);

  localparam int PW = (PERIOD_CLK_COUNT > 1) ? $clog2(PERIOD_CLK_COUNT) : 1;
  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CLK_COUNT - 1);
  localparam logic [SW-1:0] STEP_LAST   = SW'(STEP_PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_HOLD,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_period_cnt;
  logic [SW-1:0] r_step_cnt;
  logic [N-1:0]  r_target;
  logic [N-1:0]  r_step;
  logic [N-1:0]  r_duty;
  logic          r_en;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;

  logic          w_tick;
  logic          w_step;
  logic          w_accept;
  logic [N-1:0]  w_cmd_step;
  logic [N-1:0]  w_ramp_duty;
  logic [N-1:0]  w_stop_duty;

  // One step toward tgt, computed N+1 bits wide so neither direction can wrap.
  function automatic logic [N-1:0] f_toward(
    input logic [N-1:0] cur,
    input logic [N-1:0] tgt,
    input logic [N-1:0] stp
  );
    logic [N:0] c;
    logic [N:0] t;
    logic [N:0] s;
    logic [N:0] res;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = {1'b0, stp};
    if (c < t) begin
      res = ((t - c) <= s) ? t : (c + s);
    end else begin
      res = ((c - t) <= s) ? t : (c - s);
    end
    return res[N-1:0];
  endfunction

  assign w_tick      = r_en && (r_period_cnt == PERIOD_LAST);
  assign w_step      = w_tick && (r_step_cnt == STEP_LAST);
  assign w_accept    = cmdValidIn && r_ready;
  assign w_cmd_step  = (cmdStepIn == '0) ? N'(1) : cmdStepIn;
  assign w_ramp_duty = f_toward(r_duty, r_target, r_step);
  assign w_stop_duty = f_toward(r_duty, '0, r_step);

  always_ff @(posedge clkIn or negedge rstnIn) begin
    if (!rstnIn) begin
      r_state      <= S_IDLE;
      r_period_cnt <= '0;
      r_step_cnt   <= '0;
      r_target     <= '0;
      r_step       <= '0;
      r_duty       <= '0;
      r_en         <= 1'b0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Counters track the pwm instance, so they only move while it is enabled.
      if (r_en) begin
        r_period_cnt <= w_tick ? '0 : r_period_cnt + PW'(1);
      end
      if (w_tick) begin
        r_step_cnt <= (r_step_cnt == STEP_LAST) ? '0 : r_step_cnt + SW'(1);
      end

      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          if (w_accept) begin
            r_target     <= cmdTargetIn;
            r_step       <= w_cmd_step;
            r_period_cnt <= '0;
            r_step_cnt   <= '0;
            r_en         <= 1'b1;
            r_duty       <= '0;
            if (cmdTargetIn == '0) begin
              r_state <= S_HOLD;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RAMP;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end

        S_RAMP: begin
          if (stopIn) begin
            r_state <= S_STOP;
          end else if (w_step) begin
            r_duty <= w_ramp_duty;
            if (w_ramp_duty == r_target) begin
              r_state <= S_HOLD;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end

        S_HOLD: begin
          // Stop wins over a command offered on the same cycle.
          if (stopIn) begin
            r_state <= S_STOP;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else if (w_accept) begin
            r_target   <= cmdTargetIn;
            r_step     <= w_cmd_step;
            r_step_cnt <= '0;
            if (cmdTargetIn == r_duty) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RAMP;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end

        S_STOP: begin
          if (w_step) begin
            r_duty <= w_stop_duty;
            if (w_stop_duty == '0) begin
              r_state <= S_IDLE;
              r_en    <= 1'b0;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
          r_duty  <= '0;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cmdReadyOut   = r_ready;
  assign pwmEnOut      = r_en;
  assign dutyCycleOut  = r_duty;
  assign busyOut       = r_busy;
  assign doneOut       = r_done;
  assign periodTickOut = w_tick;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - scoreboard bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;
  localparam int N = 4;
  localparam int P = 32;
  localparam int S = 2;

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic         stop = 1'b0;
  logic         pwm_en;
  logic [N-1:0] duty;
  logic         busy;
  logic         done;
  logic         tick;

  pwm_ramp_ctrl_if #(.N(N)) cmd_if ();

  pwm_ramp_ctrl #(
    .N               (N),
    .PERIOD_CLK_COUNT(P),
    .STEP_PERIODS    (S)
  ) dut (
    .clkIn        (clk),
    .rstnIn       (rstn),
    .cmdValidIn   (cmd_if.tvalid),
    .cmdReadyOut  (cmd_if.tready),
    .cmdTargetIn  (cmd_if.target),
    .cmdStepIn    (cmd_if.step),
    .stopIn       (stop),
    .pwmEnOut     (pwm_en),
    .dutyCycleOut (duty),
    .busyOut      (busy),
    .doneOut      (done),
    .periodTickOut(tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int q_duty[$];
  int q_done[$];
  logic [N-1:0] prev_duty = '0;
  logic         prev_tick = 1'b0;
  logic         prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every duty change and every done pulse pops an expectation.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_duty = '0;
      prev_tick = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (duty != prev_duty) begin
        if (q_duty.size() == 0) chk("duty_unexpected", 0, 1);
        else chk("duty", 32'(duty), q_duty.pop_front());
        chk("duty_on_tick", 32'(prev_tick), 1);
      end
      if (done) begin
        if (q_done.size() == 0) chk("done_unexpected", 0, 1);
        else chk("done_duty", 32'(duty), q_done.pop_front());
        chk("done_busy", 32'(busy), 0);
        chk("done_width", 32'(prev_done), 0);
      end
      prev_duty = duty;
      prev_tick = tick;
      prev_done = done;
    end
  end

  task automatic send_cmd(input int target, input int step);
    int i;
    i = 0;
    @(negedge clk);
    while (!cmd_if.tready && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("cmd_ready", 32'(cmd_if.tready), 1);
    cmd_if.tvalid = 1'b1;
    cmd_if.target = N'(target);
    cmd_if.step   = N'(step);
    @(posedge clk);
    #1 cmd_if.tvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic wait_duty(input string tag, input int val, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (32'(duty) == val) seen = 1'b1;
    end
    chk(tag, 32'(seen), 1);
  endtask

  initial begin
    cmd_if.tvalid = 1'b0;
    cmd_if.target = '0;
    cmd_if.step   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(pwm_en), 0);
    chk("rst_duty", 32'(duty), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_ready", 32'(cmd_if.tready), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", 32'(cmd_if.tready), 1);

    // Ramp up 0 -> 10 step 4
    q_duty.push_back(4); q_duty.push_back(8); q_duty.push_back(10);
    q_done.push_back(10);
    send_cmd(10, 4);
    @(negedge clk);
    chk("ramp_busy", 32'(busy), 1);
    chk("ramp_ready", 32'(cmd_if.tready), 0);
    chk("ramp_en", 32'(pwm_en), 1);
    wait_done("up_done", 1000);
    @(negedge clk);
    chk("hold_ready", 32'(cmd_if.tready), 1);
    chk("hold_busy", 32'(busy), 0);
    chk("hold_duty", 32'(duty), 10);
    chk("up_queue", q_duty.size(), 0);

    // Ramp down 10 -> 3 step 5
    q_duty.push_back(5); q_duty.push_back(3);
    q_done.push_back(3);
    send_cmd(3, 5);
    wait_done("down_done", 1000);

    // Target equal to current duty: done next cycle, no duty change
    q_done.push_back(3);
    send_cmd(3, 7);
    @(negedge clk);
    chk("eq_done", 32'(done), 1);
    chk("eq_duty", 32'(duty), 3);

    // Step 0 acts as step 1
    q_duty.push_back(4); q_duty.push_back(5); q_duty.push_back(6);
    q_done.push_back(6);
    send_cmd(6, 0);
    wait_done("step0_done", 1000);

    // Stop with a simultaneous command in HOLD: stop wins, latched step 1 is used
    for (int d = 5; d >= 0; d--) q_duty.push_back(d);
    q_done.push_back(0);
    @(negedge clk);
    stop = 1'b1;
    cmd_if.tvalid = 1'b1;
    cmd_if.target = N'(15);
    cmd_if.step   = N'(3);
    @(posedge clk);
    #1 cmd_if.tvalid = 1'b0;
    @(negedge clk);
    chk("stop_busy", 32'(busy), 1);
    chk("stop_ready", 32'(cmd_if.tready), 0);
    repeat (3) @(negedge clk);
    stop = 1'b0;
    wait_done("stop_hold_done", 1000);
    chk("stop_hold_en", 32'(pwm_en), 0);

    // Stop during a ramp at duty 8, step 4
    q_duty.push_back(4); q_duty.push_back(8);
    send_cmd(12, 4);
    wait_duty("reach_8", 8, 1000);
    q_duty.push_back(4); q_duty.push_back(0);
    q_done.push_back(0);
    stop = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b0;
    wait_done("stop_ramp_done", 1000);
    chk("stop_ramp_en", 32'(pwm_en), 0);
    chk("stop_ramp_ready", 32'(cmd_if.tready), 1);

    // Full-scale single step
    q_duty.push_back(15);
    q_done.push_back(15);
    send_cmd(15, 15);
    wait_done("full_done", 400);

    // Reset mid-ramp, between clock edges
    q_duty.push_back(14);
    send_cmd(0, 1);
    wait_duty("reach_14", 14, 1000);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_en", 32'(pwm_en), 0);
    chk("arst_duty", 32'(duty), 0);
    chk("arst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ready", 32'(cmd_if.tready), 1);
    chk("arst_idle_en", 32'(pwm_en), 0);
    q_duty.push_back(2); q_duty.push_back(4); q_duty.push_back(5);
    q_done.push_back(5);
    send_cmd(5, 2);
    wait_done("post_rst_done", 1000);

    repeat (2) @(negedge clk);
    chk("end_duty_queue", q_duty.size(), 0);
    chk("end_done_queue", q_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
